// File: rtl/pc_flow_ctrl.sv
// Program-counter control-flow sequencer: INIT/FETCH/EXEC/INTR cycle,
// PC/SP/scratch strobes for branches, CALL/RET and interrupts, and the
// interrupt-enable flag.
module pc_flow_ctrl #(
    parameter logic [1:0] INTR_SEL = 2'd2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INT,
    input  logic [4:0] OPCODE_HI_5,
    input  logic [1:0] OPCODE_LO_2,
    input  logic       C_FLAG,
    input  logic       Z_FLAG,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic [1:0] PC_MUX_SEL,
    output logic       SP_INCR,
    output logic       SP_DECR,
    output logic       SCR_WE,
    output logic [1:0] SCR_ADDR_SEL,
    output logic       SCR_DATA_SEL,
    output logic       FLG_SHAD_LD,
    output logic       FLG_LD_SEL,
    output logic       I_FLAG,
    output logic       RST_OUT
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_BRN   = 7'b0010000;
    localparam logic [OP_W-1:0] OP_CALL  = 7'b0010001;
    localparam logic [OP_W-1:0] OP_BREQ  = 7'b0010010;
    localparam logic [OP_W-1:0] OP_BRNE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRCS  = 7'b0010100;
    localparam logic [OP_W-1:0] OP_BRCC  = 7'b0010101;
    localparam logic [OP_W-1:0] OP_RET   = 7'b0110010;
    localparam logic [OP_W-1:0] OP_SEI   = 7'b0110100;
    localparam logic [OP_W-1:0] OP_CLI   = 7'b0110101;
    localparam logic [OP_W-1:0] OP_RETID = 7'b0110110;
    localparam logic [OP_W-1:0] OP_RETIE = 7'b0110111;

    localparam logic [1:0] SEL_IMMED = 2'd0;
    localparam logic [1:0] SEL_STACK = 2'd1;
    localparam logic [1:0] ADDR_SP   = 2'd0;
    localparam logic [1:0] ADDR_SP_M1 = 2'd1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            i_flag_q, i_flag_d;
    logic [OP_W-1:0] opcode;

    assign opcode = {OPCODE_HI_5, OPCODE_LO_2};
    assign I_FLAG = i_flag_q;

    // State and interrupt-enable registers; reset wins over every transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_INIT;
            i_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_flag_q <= i_flag_d;
        end
    end

    // Next-state, interrupt-enable update and combinational strobes.
    always_comb begin
        state_d      = state_q;
        i_flag_d     = i_flag_q;
        PC_LD        = 1'b0;
        PC_INC       = 1'b0;
        PC_MUX_SEL   = SEL_IMMED;
        SP_INCR      = 1'b0;
        SP_DECR      = 1'b0;
        SCR_WE       = 1'b0;
        SCR_ADDR_SEL = ADDR_SP;
        SCR_DATA_SEL = 1'b0;
        FLG_SHAD_LD  = 1'b0;
        FLG_LD_SEL   = 1'b0;
        RST_OUT      = 1'b0;

        case (state_q)
            ST_INIT: begin
                RST_OUT = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                PC_INC  = 1'b1;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                case (opcode)
                    OP_BRN:  PC_LD = 1'b1;
                    OP_BREQ: PC_LD = Z_FLAG;
                    OP_BRNE: PC_LD = ~Z_FLAG;
                    OP_BRCS: PC_LD = C_FLAG;
                    OP_BRCC: PC_LD = ~C_FLAG;
                    OP_CALL: begin
                        // PC was already incremented in FETCH, so it is the return address.
                        PC_LD        = 1'b1;
                        SCR_WE       = 1'b1;
                        SCR_ADDR_SEL = ADDR_SP_M1;
                        SCR_DATA_SEL = 1'b1;
                        SP_DECR      = 1'b1;
                    end
                    OP_RET: begin
                        PC_LD      = 1'b1;
                        PC_MUX_SEL = SEL_STACK;
                        SP_INCR    = 1'b1;
                    end
                    OP_RETID, OP_RETIE: begin
                        PC_LD      = 1'b1;
                        PC_MUX_SEL = SEL_STACK;
                        SP_INCR    = 1'b1;
                        FLG_LD_SEL = 1'b1;
                        i_flag_d   = opcode[0];
                    end
                    OP_SEI: i_flag_d = 1'b1;
                    OP_CLI: i_flag_d = 1'b0;
                    default: ;
                endcase
                // Interrupt check uses the enable value before this instruction.
                state_d = (INT && i_flag_q) ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                PC_LD        = 1'b1;
                PC_MUX_SEL   = INTR_SEL;
                SCR_WE       = 1'b1;
                SCR_ADDR_SEL = ADDR_SP_M1;
                SCR_DATA_SEL = 1'b1;
                SP_DECR      = 1'b1;
                FLG_SHAD_LD  = 1'b1;
                i_flag_d     = 1'b0;
                state_d      = ST_FETCH;
            end

            default: state_d = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_pc_flow_ctrl;

    localparam logic [6:0] OP_NOP   = 7'b0000000;
    localparam logic [6:0] OP_BRN   = 7'b0010000;
    localparam logic [6:0] OP_CALL  = 7'b0010001;
    localparam logic [6:0] OP_BREQ  = 7'b0010010;
    localparam logic [6:0] OP_BRNE  = 7'b0010011;
    localparam logic [6:0] OP_BRCS  = 7'b0010100;
    localparam logic [6:0] OP_BRCC  = 7'b0010101;
    localparam logic [6:0] OP_RET   = 7'b0110010;
    localparam logic [6:0] OP_SEI   = 7'b0110100;
    localparam logic [6:0] OP_CLI   = 7'b0110101;
    localparam logic [6:0] OP_RETID = 7'b0110110;
    localparam logic [6:0] OP_RETIE = 7'b0110111;

    localparam int PH_INIT  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_INTR  = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       INT = 1'b0;
    logic [6:0] op  = OP_NOP;
    logic       C_FLAG = 1'b0;
    logic       Z_FLAG = 1'b0;
    logic       PC_LD, PC_INC, SP_INCR, SP_DECR, SCR_WE, SCR_DATA_SEL;
    logic       FLG_SHAD_LD, FLG_LD_SEL, I_FLAG, RST_OUT;
    logic [1:0] PC_MUX_SEL, SCR_ADDR_SEL;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pc_flow_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .INT          (INT),
        .OPCODE_HI_5  (op[6:2]),
        .OPCODE_LO_2  (op[1:0]),
        .C_FLAG       (C_FLAG),
        .Z_FLAG       (Z_FLAG),
        .PC_LD        (PC_LD),
        .PC_INC       (PC_INC),
        .PC_MUX_SEL   (PC_MUX_SEL),
        .SP_INCR      (SP_INCR),
        .SP_DECR      (SP_DECR),
        .SCR_WE       (SCR_WE),
        .SCR_ADDR_SEL (SCR_ADDR_SEL),
        .SCR_DATA_SEL (SCR_DATA_SEL),
        .FLG_SHAD_LD  (FLG_SHAD_LD),
        .FLG_LD_SEL   (FLG_LD_SEL),
        .I_FLAG       (I_FLAG),
        .RST_OUT      (RST_OUT)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Output word: {ld, inc, sel[1:0], sp+, sp-, we, addr[1:0], data, shad, lds, ien, rst}
    function automatic logic [13:0] model_out(input int ph, input bit ien, input logic [6:0] o,
                                              input bit c, input bit z);
        bit ld, inc, spi, spd, we, dsel, shd, lds, rout, taken, push, pop;
        logic [1:0] sel, asel;
        ld = 0; inc = 0; spi = 0; spd = 0; we = 0; dsel = 0; shd = 0; lds = 0; rout = 0;
        sel = 2'd0; asel = 2'd0;
        taken = 0; push = 0; pop = 0;
        if (ph == PH_INIT) rout = 1;
        else if (ph == PH_FETCH) inc = 1;
        else if (ph == PH_INTR) begin
            ld = 1; sel = 2'd2; we = 1; asel = 2'd1; dsel = 1; spd = 1; shd = 1;
        end else begin
            if (o == OP_BRN) taken = 1;
            if (o == OP_BREQ) taken = z;
            if (o == OP_BRNE) taken = !z;
            if (o == OP_BRCS) taken = c;
            if (o == OP_BRCC) taken = !c;
            push = (o == OP_CALL);
            pop  = (o == OP_RET) || (o == OP_RETID) || (o == OP_RETIE);
            if (taken || push) ld = 1;
            if (push) begin we = 1; asel = 2'd1; dsel = 1; spd = 1; end
            if (pop) begin ld = 1; sel = 2'd1; spi = 1; end
            lds = (o == OP_RETID) || (o == OP_RETIE);
        end
        return {ld, inc, sel, spi, spd, we, asel, dsel, shd, lds, ien, rout};
    endfunction

    // Behavioural model: phase of the instruction cycle and the enable flag.
    int m_ph    = PH_INIT;
    bit m_ien   = 0;
    bit m_valid = 0;

    // Compare every cycle, then advance the model to the state after the next edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("outputs", {PC_LD, PC_INC, PC_MUX_SEL, SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL,
                            SCR_DATA_SEL, FLG_SHAD_LD, FLG_LD_SEL, I_FLAG, RST_OUT},
                model_out(m_ph, m_ien, op, C_FLAG, Z_FLAG));
            chk("sp_incr_and_decr", SP_INCR & SP_DECR, 0);
            chk("pc_ld_and_inc", PC_LD & PC_INC, 0);
        end
        if (RST) begin
            m_ph = PH_INIT; m_ien = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_ph == PH_INIT) m_ph = PH_FETCH;
            else if (m_ph == PH_FETCH) m_ph = PH_EXEC;
            else if (m_ph == PH_INTR) begin m_ph = PH_FETCH; m_ien = 0; end
            else begin
                m_ph = (INT && m_ien) ? PH_INTR : PH_FETCH;
                if (op == OP_SEI || op == OP_RETIE) m_ien = 1;
                if (op == OP_CLI || op == OP_RETID) m_ien = 0;
            end
        end
    end

    // One cycle: drive inputs just after the edge, return at the following negedge.
    task automatic tick(input bit r, input bit i, input logic [6:0] o, input bit c, input bit z);
        @(posedge CLK);
        #1;
        RST = r; INT = i; op = o; C_FLAG = c; Z_FLAG = z;
        @(negedge CLK);
    endtask

    // FETCH then EXEC of one instruction; returns in the EXEC cycle.
    task automatic instr(input logic [6:0] o, input bit i, input bit c, input bit z);
        tick(0, i, o, c, z);
        tick(0, i, o, c, z);
    endtask

    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return OP_BRN;   1: return OP_CALL;  2: return OP_BREQ;
            3: return OP_BRNE;  4: return OP_BRCS;  5: return OP_BRCC;
            6: return OP_RET;   7: return OP_SEI;   8: return OP_CLI;
            9: return OP_RETID; 10: return OP_RETIE;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        bit saw_intr;
        // Reset held for two edges.
        tick(1, 0, OP_NOP, 0, 0);
        chk("reset_rst_out_0", RST_OUT, 1);
        tick(0, 0, OP_NOP, 0, 0);
        chk("reset_rst_out_1", RST_OUT, 1);
        chk("reset_pc_inc", PC_INC, 0);
        chk("reset_i_flag", I_FLAG, 0);
        tick(0, 0, OP_NOP, 0, 0);
        chk("first_fetch_inc", PC_INC, 1);
        chk("first_fetch_rst_out", RST_OUT, 0);

        // Conditional branches.
        tick(0, 0, OP_BREQ, 0, 1);
        chk("breq_z1_ld", PC_LD, 1);
        chk("breq_z1_sel", PC_MUX_SEL, 0);
        chk("exec_no_inc", PC_INC, 0);
        instr(OP_BREQ, 0, 0, 0);
        chk("breq_z0_ld", PC_LD, 0);
        instr(OP_BRCC, 0, 0, 1);
        chk("brcc_c0_ld", PC_LD, 1);
        instr(OP_BRCS, 0, 0, 1);
        chk("brcs_c0_ld", PC_LD, 0);

        // CALL then RET.
        instr(OP_CALL, 0, 0, 0);
        chk("call_strobes", {SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, SP_DECR, SP_INCR, PC_LD, PC_MUX_SEL},
            {1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0});
        instr(OP_RET, 0, 0, 0);
        chk("ret_strobes", {SCR_WE, SCR_ADDR_SEL, SP_INCR, SP_DECR, PC_LD, PC_MUX_SEL},
            {1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1});

        // SEI with INT high does not interrupt on its own EXEC.
        instr(OP_SEI, 1, 0, 0);
        chk("sei_i_flag_old", I_FLAG, 0);
        tick(0, 1, OP_NOP, 0, 0);
        chk("after_sei_fetch", PC_INC, 1);
        chk("after_sei_i_flag", I_FLAG, 1);
        tick(0, 1, OP_NOP, 0, 0);
        chk("nop_exec_ld", PC_LD, 0);
        tick(0, 0, OP_NOP, 0, 0);
        chk("intr_strobes", {PC_LD, PC_MUX_SEL, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, SP_DECR, FLG_SHAD_LD},
            {1'b1, 2'd2, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1});
        instr(OP_RETIE, 0, 0, 0);
        chk("retie_i_flag_old", I_FLAG, 0);
        chk("retie_flg_ld_sel", FLG_LD_SEL, 1);
        chk("retie_sel", PC_MUX_SEL, 1);

        // CLI with INT high while enabled still takes the interrupt.
        tick(0, 0, OP_NOP, 0, 0);
        chk("after_retie_i_flag", I_FLAG, 1);
        tick(0, 1, OP_CLI, 0, 0);
        tick(0, 0, OP_NOP, 0, 0);
        chk("cli_intr_taken", {PC_LD, PC_MUX_SEL}, {1'b1, 2'd2});

        // Masked: INT held high for 10 cycles with interrupts disabled.
        saw_intr = 0;
        for (int k = 0; k < 10; k++) begin
            tick(0, 1, OP_NOP, 0, 0);
            if (PC_MUX_SEL == 2'd2 || FLG_SHAD_LD) saw_intr = 1;
        end
        chk("masked_no_intr", saw_intr, 0);

        // Reset at the edge ending CALL's EXEC while an interrupt is pending.
        instr(OP_SEI, 0, 0, 0);
        tick(0, 1, OP_NOP, 0, 0);
        chk("pre_abort_i_flag", I_FLAG, 1);
        tick(1, 1, OP_CALL, 0, 0);
        chk("abort_call_exec_we", SCR_WE, 1);
        tick(0, 1, OP_NOP, 0, 0);
        chk("abort_init", {RST_OUT, I_FLAG, PC_LD, SCR_WE, FLG_SHAD_LD}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tick(0, 1, OP_NOP, 0, 0);
        chk("abort_then_fetch", PC_INC, 1);

        // Randomized phase checked by the model.
        for (int n = 0; n < 4000; n++) begin
            tick(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
                 pick_op($urandom_range(0, 14)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
